lsu_mem_port: RTL and testbench

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_mem_port_if.sv | 25 ++
 rtl/lsu_mem_port.sv | 121 ++++++++++++
 tb/tb_lsu_mem_port.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
// CPU-side load/store request and response bundle for lsu_mem_port.
// master = CPU pipeline, slave = the memory port.
interface lsu_mem_port_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic [31:0] resp_badaddr;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err, resp_badaddr
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err, resp_badaddr
   );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding RISC-V load/store port to a lane-addressed data memory.
// Response two edges after accept (one for errors); held in RESP until resp_ready.
module lsu_mem_port #(
   parameter int ADDR_WIDTH = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   lsu_mem_port_if.slave cpu,
   output logic [3:0]    mem_wmem,
   output logic [4:0]    mem_rmem,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_store_data,
   input  logic [31:0]   mem_load_data
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] STORE = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]  state;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [1:0]  err_q;
   logic [31:0] badaddr_q;

   logic        illegal;
   logic        misaligned;
   logic        out_of_range;
   logic [1:0]  acc_err;
   logic [29:0] word_addr;
   logic [3:0]  lanes;
   logic        sext;
   logic        active;

   // Error classification on the raw request; only meaningful while IDLE.
   always_comb begin
      word_addr = cpu.req_addr[31:2];
      if (cpu.req_we)
         illegal = cpu.req_funct3[2];
      else
         illegal = (cpu.req_funct3 == 3'b011) || (cpu.req_funct3[2:1] == 2'b11);
      misaligned = ((cpu.req_funct3[1:0] == 2'b01) && cpu.req_addr[0]) ||
                   (cpu.req_funct3[1] && (cpu.req_addr[1:0] != 2'b00));
      out_of_range = (word_addr >> ADDR_WIDTH) != 30'd0;
      if (illegal)
         acc_err = 2'b11;
      else if (misaligned)
         acc_err = 2'b01;
      else if (out_of_range)
         acc_err = 2'b10;
      else
         acc_err = 2'b00;
   end

   always_comb begin
      case (f3_q[1:0])
         2'b00:   lanes = 4'b0001 << addr_q[1:0];
         2'b01:   lanes = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lanes = 4'b1111;
      endcase
      sext = ~f3_q[2] & ~f3_q[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         f3_q      <= 3'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         rdata_q   <= 32'd0;
         err_q     <= 2'b00;
         badaddr_q <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu.req_valid) begin
                  f3_q      <= cpu.req_funct3;
                  addr_q    <= cpu.req_addr;
                  wdata_q   <= cpu.req_wdata;
                  rdata_q   <= 32'd0;
                  err_q     <= acc_err;
                  badaddr_q <= (acc_err != 2'b00) ? cpu.req_addr : 32'd0;
                  if (acc_err != 2'b00)
                     state <= RESP;
                  else if (cpu.req_we)
                     state <= STORE;
                  else
                     state <= LOAD;
               end
            end
            LOAD: begin
               rdata_q <= mem_load_data;
               state   <= RESP;
            end
            STORE: state <= RESP;
            RESP: begin
               if (cpu.resp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory strobes decode straight from state so a reset mid-access drops them at once.
   assign active         = (state == LOAD) || (state == STORE);
   assign mem_addr       = active ? {2'b00, addr_q[31:2]} : 32'd0;
   assign mem_rmem       = (state == LOAD) ? {sext, lanes} : 5'd0;
   assign mem_wmem       = (state == STORE) ? lanes : 4'd0;
   assign mem_store_data = (state == STORE) ? wdata_q : 32'd0;

   assign cpu.req_ready    = (state == IDLE);
   assign cpu.resp_valid   = (state == RESP);
   assign cpu.resp_rdata   = cpu.resp_valid ? rdata_q : 32'd0;
   assign cpu.resp_err     = cpu.resp_valid ? err_q : 2'b00;
   assign cpu.resp_badaddr = cpu.resp_valid ? badaddr_q : 32'd0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a small lane-placing, extending data memory model.
module tb_lsu_mem_port;
   logic        clk;
   logic        rst_n;
   logic [3:0]  mem_wmem;
   logic [4:0]  mem_rmem;
   logic [31:0] mem_addr;
   logic [31:0] mem_store_data;
   logic [31:0] mem_load_data;
   logic        preload;
   int          total;
   int          bad;

   lsu_mem_port_if bus ();

   lsu_mem_port #(.ADDR_WIDTH(15)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cpu            (bus.slave),
      .mem_wmem       (mem_wmem),
      .mem_rmem       (mem_rmem),
      .mem_addr       (mem_addr),
      .mem_store_data (mem_store_data),
      .mem_load_data  (mem_load_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: 16 words indexed by the low word-address bits.
   logic [31:0] mem [16];
   logic [31:0] placed;
   logic [31:0] rd_word;
   logic [31:0] rd_shift;
   int          wsh;
   int          rsh;

   always_comb begin
      wsh = mem_wmem[0] ? 0 : mem_wmem[1] ? 1 : mem_wmem[2] ? 2 : 3;
      placed = mem_store_data << (8 * wsh);
   end

   always @(posedge clk) begin
      if (preload) begin
         mem[4] <= 32'h8899AABB;
         mem[8] <= 32'h11223344;
      end else if (mem_wmem != 4'd0) begin
         for (int k = 0; k < 4; k++)
            if (mem_wmem[k]) mem[mem_addr[3:0]][8*k +: 8] <= placed[8*k +: 8];
      end
   end

   always_comb begin
      rsh = mem_rmem[0] ? 0 : mem_rmem[1] ? 1 : mem_rmem[2] ? 2 : 3;
      rd_word = mem[mem_addr[3:0]];
      rd_shift = rd_word >> (8 * rsh);
      mem_load_data = 32'd0;
      if (mem_rmem[3:0] == 4'b1111)
         mem_load_data = rd_word;
      else if (mem_rmem[3:0] == 4'b0011 || mem_rmem[3:0] == 4'b1100)
         mem_load_data = mem_rmem[4] ? {{16{rd_shift[15]}}, rd_shift[15:0]} : {16'd0, rd_shift[15:0]};
      else if (mem_rmem[3:0] != 4'b0000)
         mem_load_data = mem_rmem[4] ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'd0, rd_shift[7:0]};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete transaction; hold = cycles of response backpressure with a stray req_valid.
   task automatic access(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] exp_err, input logic [31:0] exp_rdata,
                         input logic [4:0] exp_sel, input int hold);
      @(negedge clk);
      chk({tag, "/req_ready"}, {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      if (exp_err == 2'b00) begin
         if (we) begin
            chk({tag, "/wmem"}, {28'd0, mem_wmem}, {28'd0, exp_sel[3:0]});
            chk({tag, "/store_data"}, mem_store_data, wdata);
            chk({tag, "/rmem_in_store"}, {27'd0, mem_rmem}, 32'd0);
         end else begin
            chk({tag, "/rmem"}, {27'd0, mem_rmem}, {27'd0, exp_sel});
            chk({tag, "/wmem_in_load"}, {28'd0, mem_wmem}, 32'd0);
         end
         chk({tag, "/mem_addr"}, mem_addr, {2'b00, addr[31:2]});
         chk({tag, "/early_valid"}, {31'd0, bus.resp_valid}, 32'd0);
         @(negedge clk);
      end else begin
         chk({tag, "/err_wmem"}, {28'd0, mem_wmem}, 32'd0);
         chk({tag, "/err_rmem"}, {27'd0, mem_rmem}, 32'd0);
      end
      chk({tag, "/resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
      chk({tag, "/resp_wmem"}, {28'd0, mem_wmem}, 32'd0);
      chk({tag, "/resp_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "/rdata"}, bus.resp_rdata, exp_rdata);
      chk({tag, "/err"}, {30'd0, bus.resp_err}, {30'd0, exp_err});
      chk({tag, "/badaddr"}, bus.resp_badaddr, (exp_err != 2'b00) ? addr : 32'd0);
      for (int i = 0; i < hold; i++) begin
         bus.req_valid = 1'b1;
         bus.req_we    = 1'b1;
         bus.req_addr  = 32'h0000_0020;
         @(negedge clk);
         chk({tag, "/bp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
         chk({tag, "/bp_rdata"}, bus.resp_rdata, exp_rdata);
         chk({tag, "/bp_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
         chk({tag, "/bp_wmem"}, {28'd0, mem_wmem}, 32'd0);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
      chk({tag, "/hs_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
      @(negedge clk);
      chk({tag, "/done_valid"}, {31'd0, bus.resp_valid}, 32'd0);
   endtask

   initial begin
      total = 0;
      bad = 0;
      preload = 1'b1;
      rst_n = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.resp_ready = 1'b0;
      #1;
      chk("rst/req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst/resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst/wmem", {28'd0, mem_wmem}, 32'd0);
      chk("rst/rmem", {27'd0, mem_rmem}, 32'd0);
      chk("rst/mem_addr", mem_addr, 32'd0);
      chk("rst/rdata", bus.resp_rdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      preload = 1'b0;
      rst_n = 1'b1;

      access("lb_bp", 1'b0, 3'b000, 32'h12, 32'd0, 2'b00, 32'hFFFFFF99, 5'b10100, 3);
      access("lhu",   1'b0, 3'b101, 32'h12, 32'd0, 2'b00, 32'h00008899, 5'b01100, 0);
      access("sb",    1'b1, 3'b000, 32'h13, 32'h123456C5, 2'b00, 32'd0, 5'b01000, 0);
      access("lbu",   1'b0, 3'b100, 32'h13, 32'd0, 2'b00, 32'h000000C5, 5'b01000, 0);
      access("lh",    1'b0, 3'b001, 32'h12, 32'd0, 2'b00, 32'hFFFFC599, 5'b11100, 0);
      access("sw_top", 1'b1, 3'b010, 32'h0001FFFC, 32'h0BADF00D, 2'b00, 32'd0, 5'b01111, 0);
      access("lw_top", 1'b0, 3'b010, 32'h0001FFFC, 32'd0, 2'b00, 32'h0BADF00D, 5'b01111, 0);
      access("lw_mis",  1'b0, 3'b010, 32'h06, 32'd0, 2'b01, 32'd0, 5'd0, 0);
      access("ld_f110", 1'b0, 3'b110, 32'h00, 32'd0, 2'b11, 32'd0, 5'd0, 0);
      access("sw_oor",  1'b1, 3'b010, 32'h00020000, 32'h1, 2'b10, 32'd0, 5'd0, 0);
      access("sb_ill",  1'b1, 3'b100, 32'h10, 32'h1, 2'b11, 32'd0, 5'd0, 0);
      access("ill_mis", 1'b0, 3'b111, 32'h01, 32'd0, 2'b11, 32'd0, 5'd0, 0);
      access("mis_oor", 1'b0, 3'b001, 32'h00020001, 32'd0, 2'b01, 32'd0, 5'd0, 0);

      // Reset asserted while the store strobe is live.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h20;
      bus.req_wdata  = 32'hDEADBEEF;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      #1;
      chk("rst_mid/wmem_before", {28'd0, mem_wmem}, 32'h0000000F);
      rst_n = 1'b0;
      #1;
      chk("rst_mid/wmem", {28'd0, mem_wmem}, 32'd0);
      chk("rst_mid/mem_addr", mem_addr, 32'd0);
      chk("rst_mid/resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid/req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_mid/no_resp", {31'd0, bus.resp_valid}, 32'd0);
      access("lw_after_rst", 1'b0, 3'b010, 32'h20, 32'd0, 2'b00, 32'h11223344, 5'b01111, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
